// File: rtl/store_rmw_if.sv
// Store request / data-memory port bundle for store_rmw_unit.
// slave  : the store unit (consumes requests, drives the memory port)
// master : the datapath + memory side (drives requests, answers reads/writes)
interface store_rmw_if #(
    parameter int ADDR_W = 32
);
    // datapath store request
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        store_type;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    // data-memory port (word granular, no byte enables)
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              mem_wr_ack;

    // completion status back to the stall logic
    logic              done;
    logic              misaligned;
    logic [3:0]        byte_en;

    modport slave (
        input  req_valid, store_type, addr, wdata,
        input  mem_rdata, mem_rd_valid, mem_wr_ack,
        output req_ready,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output done, misaligned, byte_en
    );

    modport master (
        output req_valid, store_type, addr, wdata,
        output mem_rdata, mem_rd_valid, mem_wr_ack,
        input  req_ready,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  done, misaligned, byte_en
    );
endinterface

// File: rtl/store_rmw_unit.sv
// Store read-modify-write unit.
// Turns byte/halfword stores into full-word writes for a memory without
// byte enables: read the aligned word, merge the new lanes, write it back.
// Aligned word stores may skip the read (WORD_FAST). Misaligned or reserved
// stores complete immediately with misaligned=1 and never touch memory.
// One store in flight; all outputs come straight from registers.
module store_rmw_unit #(
    parameter int ADDR_W    = 32,
    parameter bit WORD_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    store_rmw_if.slave  bus
);

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;

    // registered outputs
    logic              ready_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q;
    logic              mis_q;
    logic [3:0]        be_q;

    // request fields latched at accept
    logic [31:0]       wdata_q;
    logic [1:0]        type_q;
    logic [1:0]        off_q;

    // decode of the incoming request
    logic [1:0]        off_in;
    logic [3:0]        be_in;
    logic              mis_in;

    // merge path
    logic [31:0]       sh_data;
    logic [31:0]       merged;

    assign off_in = bus.addr[1:0];

    // Lane enables for the incoming request, and the alignment/reserved check.
    always_comb begin
        be_in  = 4'b0000;
        mis_in = 1'b0;
        case (bus.store_type)
            ST_WORD: begin
                if (off_in == 2'b00) be_in  = 4'b1111;
                else                 mis_in = 1'b1;
            end
            ST_HALF: begin
                if (off_in[0])       mis_in = 1'b1;
                else                 be_in  = off_in[1] ? 4'b1100 : 4'b0011;
            end
            ST_BYTE: begin
                be_in = 4'b0001 << off_in;
            end
            default: begin
                mis_in = 1'b1;
            end
        endcase
    end

    // Steer the right-justified store data into its lanes. The byte is
    // replicated into every lane; be_q picks the one that is really written.
    always_comb begin
        sh_data = wdata_q;
        case (type_q)
            ST_HALF: sh_data = off_q[1] ? {wdata_q[15:0], 16'h0000}
                                        : {16'h0000, wdata_q[15:0]};
            ST_BYTE: sh_data = {4{wdata_q[7:0]}};
            default: sh_data = wdata_q;
        endcase
    end

    // Per-lane select between new store data and the word read from memory.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be_q[i] ? sh_data[8*i +: 8]
                                          : bus.mem_rdata[8*i +: 8];
    end

    // Control FSM; every output is a register set on the transition into the
    // state that owns it, so an async reset drops the enables immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            type_q      <= 2'b00;
            off_q       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q    <= 1'b0;
                        mem_addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                        wdata_q    <= bus.wdata;
                        type_q     <= bus.store_type;
                        off_q      <= off_in;
                        if (mis_in) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                            be_q   <= 4'b0000;
                        end else if (WORD_FAST && bus.store_type == ST_WORD) begin
                            state       <= WRITE;
                            wr_en_q     <= 1'b1;
                            mem_wdata_q <= bus.wdata;
                            be_q        <= be_in;
                        end else begin
                            state   <= READ;
                            rd_en_q <= 1'b1;
                            be_q    <= be_in;
                        end
                    end
                end

                READ: begin
                    if (bus.mem_rd_valid) begin
                        state       <= WRITE;
                        rd_en_q     <= 1'b0;
                        wr_en_q     <= 1'b1;
                        mem_wdata_q <= merged;
                    end
                end

                WRITE: begin
                    if (bus.mem_wr_ack) begin
                        state   <= DONE;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    be_q    <= 4'b0000;
                    ready_q <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    be_q    <= 4'b0000;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_wr_en  = wr_en_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.done       = done_q;
    assign bus.misaligned = mis_q;
    assign bus.byte_en    = be_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed stores against a scripted memory,
// expectations queued at issue time and checked when done fires.
module tb_store_rmw_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_rmw_if #(.ADDR_W(32)) bus0 ();
    store_rmw_if #(.ADDR_W(32)) bus1 ();

    store_rmw_unit #(.ADDR_W(32), .WORD_FAST(1'b1)) u_fast (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    store_rmw_unit #(.ADDR_W(32), .WORD_FAST(1'b0)) u_slow (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          mis;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];

    // ---------------- memory model for the fast instance ----------------
    logic [31:0] mem_word  = '0;
    int          rd_delay  = 0;
    int          wr_delay  = 0;
    bit          stray_ack = 0;
    int          rd_cnt_m  = 0;
    int          wr_cnt_m  = 0;

    always @(negedge clk) begin
        bus0.mem_rdata = mem_word;
        if (bus0.mem_rd_en) begin
            bus0.mem_rd_valid = (rd_cnt_m == rd_delay);
            rd_cnt_m++;
        end else begin
            bus0.mem_rd_valid = 1'b0;
            rd_cnt_m = 0;
        end
        if (bus0.mem_wr_en) begin
            bus0.mem_wr_ack = (wr_cnt_m == wr_delay);
            wr_cnt_m++;
        end else begin
            bus0.mem_wr_ack = stray_ack && bus0.mem_rd_en;
            wr_cnt_m = 0;
        end
    end

    // ---------------- monitor for the fast instance ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    bit          stable = 1;
    bit          excl = 1;
    bit          prev_done = 0;
    logic [31:0] w_last = '0;
    logic [31:0] a_last = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst && bus0.req_valid && bus0.req_ready) begin
            acc_cyc = cyc;
            rd_seen = 0;
            wr_seen = 0;
            stable  = 1;
            excl    = 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 0;
        end else begin
            if (prev_done) chk("ready_after_done", bus0.req_ready, 1);
            if (bus0.mem_rd_en) rd_seen++;
            if (bus0.mem_wr_en) begin
                if (wr_seen > 0 && bus0.mem_wdata !== w_last) stable = 0;
                w_last = bus0.mem_wdata;
                a_last = bus0.mem_addr;
                wr_seen++;
            end
            if (bus0.mem_rd_en && bus0.mem_wr_en) excl = 0;
            if (bus0.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending store");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("misaligned", bus0.misaligned, e.mis);
                    chk("latency", cyc - acc_cyc + 1, e.lat);
                    chk("byte_en", bus0.byte_en, e.be);
                    chk("rd_cycles", rd_seen, e.rd);
                    chk("wr_cycles", wr_seen, e.wr);
                    chk("rd_wr_exclusive", excl, 1);
                    if (!e.mis) begin
                        chk("mem_wdata", w_last, e.wdata);
                        chk("mem_addr", a_last, e.addr);
                        chk("wdata_stable", stable, 1);
                    end
                end
            end
            prev_done = bus0.done;
        end
    end

    // ---------------- slow instance (WORD_FAST=0): zero-wait memory ----------------
    int          rd1 = 0;
    bit          done1 = 0;
    logic [31:0] w1 = '0;

    always @(negedge clk) begin
        bus1.mem_rdata    = 32'h5555_5555;
        bus1.mem_rd_valid = bus1.mem_rd_en;
        bus1.mem_wr_ack   = bus1.mem_wr_en;
        if (!rst) begin
            if (bus1.mem_rd_en) rd1++;
            if (bus1.mem_wr_en) w1 = bus1.mem_wdata;
            if (bus1.done) done1 = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdat, input int rdl, input int wrl,
                             input bit stray, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!bus0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        mem_word  = rdat;
        rd_delay  = rdl;
        wr_delay  = wrl;
        stray_ack = stray;
        bus0.store_type = t;
        bus0.addr       = a;
        bus0.wdata      = d;
        bus0.req_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus0.req_valid  = 1'b0;
        bus0.addr       = 32'hFFFF_FFFF;
        bus0.wdata      = 32'h0;
        bus0.store_type = 2'b11;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending stores expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdat, input int rdl, input int wrl, input bit stray,
                         input logic [31:0] ew, input logic [3:0] ebe, input bit emis,
                         input int elat, input int erd, input int ewr);
        exp_t e;
        e.wdata = ew;
        e.addr  = {a[31:2], 2'b00};
        e.be    = ebe;
        e.mis   = emis;
        e.lat   = elat;
        e.rd    = erd;
        e.wr    = ewr;
        drive_req(t, a, d, rdat, rdl, wrl, stray, e);
        wait_drain();
    endtask

    initial begin
        bus0.req_valid = 0; bus0.store_type = 0; bus0.addr = 0; bus0.wdata = 0;
        bus1.req_valid = 0; bus1.store_type = 0; bus1.addr = 0; bus1.wdata = 0;

        // reset state
        #12;
        chk("rst_req_ready", bus0.req_ready, 1);
        chk("rst_rd_en", bus0.mem_rd_en, 0);
        chk("rst_wr_en", bus0.mem_wr_en, 0);
        chk("rst_mem_addr", bus0.mem_addr, 0);
        chk("rst_mem_wdata", bus0.mem_wdata, 0);
        chk("rst_done_mis_be", {bus0.done, bus0.misaligned, bus0.byte_en}, 0);
        @(negedge clk);
        rst = 0;

        //      type   addr          wdata         rdata        rdl wrl stray expected      be       mis lat rd wr
        store(2'b10, 32'h0000_1003, 32'h0000_00AB, 32'h1122_3344, 0, 0, 0, 32'hAB22_3344, 4'b1000, 0, 3, 1, 1);
        store(2'b01, 32'h0000_2002, 32'hFFFF_8765, 32'hDEAD_BEEF, 0, 0, 0, 32'h8765_BEEF, 4'b1100, 0, 3, 1, 1);
        store(2'b00, 32'h0000_3000, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0, 0, 0, 32'hCAFE_F00D, 4'b1111, 0, 2, 0, 1);
        store(2'b01, 32'h0000_4001, 32'h0000_1234, 32'h0,         0, 0, 0, 32'h0,         4'b0000, 1, 1, 0, 0);
        store(2'b00, 32'h0000_4002, 32'h1234_5678, 32'h0,         0, 0, 0, 32'h0,         4'b0000, 1, 1, 0, 0);
        store(2'b11, 32'h0000_4000, 32'h1234_5678, 32'h0,         0, 0, 0, 32'h0,         4'b0000, 1, 1, 0, 0);
        store(2'b10, 32'h0000_5001, 32'h0000_005A, 32'h0102_0304, 3, 2, 1, 32'h0102_5A04, 4'b0010, 0, 8, 4, 3);
        store(2'b01, 32'h0000_6000, 32'h1234_BEEF, 32'hAAAA_AAAA, 0, 0, 0, 32'hAAAA_BEEF, 4'b0011, 0, 3, 1, 1);
        store(2'b10, 32'h0000_7000, 32'hFFFF_FF77, 32'h0000_0000, 0, 0, 0, 32'h0000_0077, 4'b0001, 0, 3, 1, 1);

        // word store through the WORD_FAST=0 instance: read happens, data unchanged
        begin
            int n = 0;
            @(negedge clk);
            rd1 = 0; done1 = 0;
            bus1.store_type = 2'b00;
            bus1.addr       = 32'h0000_3000;
            bus1.wdata      = 32'hCAFE_F00D;
            bus1.req_valid  = 1'b1;
            @(posedge clk);
            #1;
            bus1.req_valid  = 1'b0;
            while (!done1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("slow_done", done1, 1);
            chk("slow_rd_cycles", rd1, 1);
            chk("slow_mem_wdata", w1, 32'hCAFE_F00D);
        end

        // reset abort while in WRITE
        begin
            exp_t e;
            int n = 0;
            e.wdata = 32'h0; e.addr = 32'h0000_8000; e.be = 4'b0100; e.mis = 0;
            e.lat = 0; e.rd = 0; e.wr = 0;
            drive_req(2'b10, 32'h0000_8002, 32'h0000_00EE, 32'h0, 0, 20, 0, e);
            while (!bus0.mem_wr_en && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("abort_in_write", bus0.mem_wr_en, 1);
            #2 rst = 1;
            #1;
            chk("abort_wr_en", bus0.mem_wr_en, 0);
            chk("abort_ready", bus0.req_ready, 1);
            chk("abort_done", bus0.done, 0);
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_done", bus0.done, 0);
            rst = 0;
        end

        store(2'b10, 32'h0000_9000, 32'h0000_0011, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FF11, 4'b0001, 0, 3, 1, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
